// File: rtl/seven_segment_scan_driver.sv
// Multiplexed N-digit hex seven-segment scanner: decimal points, frame snapshot,
// leading-zero suppression, PWM brightness, per-digit blink and a guard cycle.
module seven_segment_scan_driver #(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_CYCLES = 6000,
  parameter int BRIGHT_BITS    = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit DIG_ACTIVE_LOW = 1'b1
) (
  input  logic                      clk_in,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   digit_value,
  input  logic [NUM_DIGITS-1:0]     dp,
  input  logic                      zero_fill,
  input  logic [BRIGHT_BITS-1:0]    brightness,
  input  logic [NUM_DIGITS-1:0]     blink_en,
  input  logic                      blink_tick,
  output logic [7:0]                seg_port,
  output logic [NUM_DIGITS-1:0]     dig_port,
  output logic                      frame_done
);

  localparam int CW = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int UW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PW = CW + BRIGHT_BITS;
  localparam logic [CW-1:0]         CNT_MAX = CW'(REFRESH_CYCLES - 1);
  localparam logic [UW-1:0]         CUR_MAX = UW'(NUM_DIGITS - 1);
  localparam logic [7:0]            SEG_OFF = {8{SEG_ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = {NUM_DIGITS{DIG_ACTIVE_LOW}};

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
      4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
      4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
      4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
    endcase
    return s;
  endfunction

  logic [CW-1:0]           cnt_q, cnt_d;
  logic [UW-1:0]           cur_q, cur_d;
  logic [4*NUM_DIGITS-1:0] val_q;
  logic [NUM_DIGITS-1:0]   dp_q, ben_q;
  logic                    zf_q;
  logic [BRIGHT_BITS-1:0]  bri_q;
  logic                    phase_q;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   dig_q, dig_d;
  logic                    fd_q, fd_d;

  logic                    wrap_slot, wrap_frame;
  logic [CW-1:0]           on_limit;
  logic [3:0]              nib;
  logic [NUM_DIGITS-1:0]   supp;
  logic                    run;
  logic [7:0]              lit;
  logic [NUM_DIGITS-1:0]   sel;

  assign wrap_slot  = (cnt_q == CNT_MAX);
  assign wrap_frame = wrap_slot && (cur_q == '0);
  assign cnt_d      = wrap_slot ? '0 : cnt_q + CW'(1);
  assign cur_d      = wrap_frame ? CUR_MAX : (wrap_slot ? cur_q - UW'(1) : cur_q);
  assign nib        = val_q[4*int'(cur_q) +: 4];

  // Full-width product before the shift so large REFRESH_CYCLES keeps its precision.
  assign on_limit = (&bri_q) ? CNT_MAX
                             : CW'((PW'(bri_q) * PW'(CNT_MAX)) >> BRIGHT_BITS);

  // A digit stays blank only while it and every more significant digit are bare zeros.
  always_comb begin
    supp = '0;
    run  = !zf_q;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run     = run && (val_q[4*i +: 4] == 4'h0) && !dp_q[i];
      supp[i] = run && (i != 0);
    end
  end

  always_comb begin
    lit = {dp_q[cur_q], hex_to_seg(nib)};
    if (supp[cur_q] || (phase_q && ben_q[cur_q]) || (cnt_q == '0))
      lit = 8'h00;
    seg_d = lit ^ SEG_OFF;

    sel = '0;
    if ((cnt_q != '0) && (cnt_q <= on_limit))
      sel[cur_q] = 1'b1;
    dig_d = sel ^ DIG_OFF;

    fd_d = wrap_frame;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      cur_q   <= CUR_MAX;
      phase_q <= 1'b0;
      seg_q   <= SEG_OFF;
      dig_q   <= DIG_OFF;
      fd_q    <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      cur_q <= cur_d;
      seg_q <= seg_d;
      dig_q <= dig_d;
      fd_q  <= fd_d;
      if (blink_tick)
        phase_q <= ~phase_q;
    end
  end

  // Inputs are sampled only at frame boundaries so a frame never mixes two values.
  always_ff @(posedge clk_in) begin
    if (!rst_n || wrap_frame) begin
      val_q <= digit_value;
      dp_q  <= dp;
      zf_q  <= zero_fill;
      bri_q <= brightness;
      ben_q <= blink_en;
    end
  end

  assign seg_port   = seg_q;
  assign dig_port   = dig_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seven_segment_scan_driver.sv
// Directed bench for seven_segment_scan_driver: 4 digits, 16-cycle slots, active-low pins.
module tb_seven_segment_scan_driver;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] digit_value = 16'h0000;
  logic [3:0]  dp = 4'b0000;
  logic        zero_fill = 1'b0;
  logic [3:0]  brightness = 4'hF;
  logic [3:0]  blink_en = 4'b0000;
  logic        blink_tick = 1'b0;
  logic [7:0]  seg_port;
  logic [3:0]  dig_port;
  logic        frame_done;

  int vec = 0;
  int errs = 0;
  int k = 0;

  seven_segment_scan_driver #(
    .NUM_DIGITS(4), .REFRESH_CYCLES(16), .BRIGHT_BITS(4),
    .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .digit_value(digit_value), .dp(dp),
    .zero_fill(zero_fill), .brightness(brightness), .blink_en(blink_en),
    .blink_tick(blink_tick), .seg_port(seg_port), .dig_port(dig_port),
    .frame_done(frame_done)
  );

  always #5 clk_in = ~clk_in;

  // Output seen after step k reflects counter state (cnt=(k-1)%16, slot 3-((k-1)/16)%4).
  task automatic step();
    @(posedge clk_in);
    #1;
    k++;
  endtask

  function automatic int pos_cnt();
    return (k - 1) % 16;
  endfunction

  function automatic int pos_slot();
    return 3 - (((k - 1) / 16) % 4);
  endfunction

  task automatic goto(input int slot, input int c);
    for (int n = 0; n < 300; n++) begin
      step();
      if (pos_slot() == slot && pos_cnt() == c) return;
    end
    vec++; errs++;
    $display("FAIL goto_timeout slot=%0d cnt=%0d", slot, c);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    k = 0;
  endtask

  task automatic test_reset();
    int fd_k[2];
    int nfd;
    digit_value = 16'h1234; dp = 4'b0000; zero_fill = 1'b0; brightness = 4'hF; blink_en = 4'b0000;
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      vec++;
      if (seg_port !== 8'hFF || dig_port !== 4'hF || frame_done !== 1'b0) begin
        errs++;
        $display("FAIL reset_hold cyc=%0d got seg=%h dig=%h fd=%b want seg=ff dig=f fd=0",
                 i, seg_port, dig_port, frame_done);
      end
    end
    rst_n = 1'b1;
    k = 0;
    step();
    vec++;
    if (dig_port !== 4'hF || seg_port !== 8'hFF) begin
      errs++;
      $display("FAIL first_guard got seg=%h dig=%h want seg=ff dig=f", seg_port, dig_port);
    end
    step();
    vec++;
    if (dig_port !== 4'h7 || seg_port !== 8'hF9) begin
      errs++;
      $display("FAIL first_digit got seg=%h dig=%h want seg=f9 dig=7", seg_port, dig_port);
    end
    nfd = 0;
    fd_k[0] = -1; fd_k[1] = -1;
    for (int n = 0; n < 140 && nfd < 2; n++) begin
      step();
      if (frame_done === 1'b1) begin
        fd_k[nfd] = k;
        nfd++;
      end
    end
    vec++;
    if (fd_k[0] !== 64) begin
      errs++;
      $display("FAIL frame_done_first got cycle=%0d want 64", fd_k[0]);
    end
    vec++;
    if (fd_k[1] !== 128) begin
      errs++;
      $display("FAIL frame_done_period got cycle=%0d want 128", fd_k[1]);
    end
  endtask

  task automatic test_suppress();
    logic [7:0] exp_z0[4] = '{8'hC0, 8'h88, 8'hFF, 8'hFF};
    logic [7:0] exp_z1[4] = '{8'hC0, 8'h88, 8'hC0, 8'hC0};
    logic [3:0] exp_d;
    digit_value = 16'h00A0; dp = 4'b0000; zero_fill = 1'b0; brightness = 4'hF;
    do_reset();
    for (int s = 3; s >= 0; s--) begin
      goto(s, 5);
      exp_d = ~(4'b0001 << s);
      vec++;
      if (seg_port !== exp_z0[s] || dig_port !== exp_d) begin
        errs++;
        $display("FAIL lz_suppress slot=%0d got seg=%h dig=%h want seg=%h dig=%h",
                 s, seg_port, dig_port, exp_z0[s], exp_d);
      end
    end
    goto(1, 0);
    vec++;
    if (seg_port !== 8'hFF || dig_port !== 4'hF) begin
      errs++;
      $display("FAIL guard_cycle got seg=%h dig=%h want seg=ff dig=f", seg_port, dig_port);
    end
    zero_fill = 1'b1;
    do_reset();
    for (int s = 3; s >= 0; s--) begin
      goto(s, 5);
      vec++;
      if (seg_port !== exp_z1[s]) begin
        errs++;
        $display("FAIL zero_fill slot=%0d got seg=%h want seg=%h", s, seg_port, exp_z1[s]);
      end
    end
  endtask

  task automatic test_dp_suppress();
    logic [7:0] exp_s[4] = '{8'hC0, 8'hC0, 8'h40, 8'hFF};
    digit_value = 16'h0000; dp = 4'b0100; zero_fill = 1'b0; brightness = 4'hF;
    do_reset();
    for (int s = 3; s >= 0; s--) begin
      goto(s, 7);
      vec++;
      if (seg_port !== exp_s[s]) begin
        errs++;
        $display("FAIL dp_suppress slot=%0d got seg=%h want seg=%h", s, seg_port, exp_s[s]);
      end
    end
    dp = 4'b0000;
  endtask

  task automatic test_brightness();
    logic [3:0]  bri_v[2] = '{4'h8, 4'hF};
    logic [15:0] exp_m[2] = '{16'h00FE, 16'hFFFE};
    logic [15:0] mask;
    int act;
    int fd_k[2];
    int nfd;
    digit_value = 16'h1234; zero_fill = 1'b0;
    for (int b = 0; b < 2; b++) begin
      brightness = bri_v[b];
      do_reset();
      goto(2, 15);
      mask = '0;
      for (int c = 0; c < 16; c++) begin
        step();
        if (dig_port !== 4'hF) mask[pos_cnt()] = 1'b1;
      end
      vec++;
      if (mask !== exp_m[b]) begin
        errs++;
        $display("FAIL on_window bri=%0d got cnt_mask=%h want %h", bri_v[b], mask, exp_m[b]);
      end
    end
    brightness = 4'h0;
    do_reset();
    act = 0; nfd = 0;
    fd_k[0] = -1; fd_k[1] = -1;
    for (int n = 0; n < 130; n++) begin
      step();
      if (dig_port !== 4'hF) act++;
      if (frame_done === 1'b1 && nfd < 2) begin
        fd_k[nfd] = k;
        nfd++;
      end
    end
    vec++;
    if (act !== 0) begin
      errs++;
      $display("FAIL bri0_dark got active_cycles=%0d want 0", act);
    end
    vec++;
    if (fd_k[0] !== 64 || fd_k[1] !== 128) begin
      errs++;
      $display("FAIL bri0_frame got cycles=%0d,%0d want 64,128", fd_k[0], fd_k[1]);
    end
    brightness = 4'hF;
  endtask

  task automatic test_snapshot();
    int         sl[7]    = '{2, 1, 0, 3, 2, 1, 0};
    logic [7:0] exp_s[7] = '{8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80};
    digit_value = 16'h1234; zero_fill = 1'b0; brightness = 4'hF;
    do_reset();
    goto(2, 3);
    digit_value = 16'h5678;
    for (int i = 0; i < 7; i++) begin
      goto(sl[i], 5);
      vec++;
      if (seg_port !== exp_s[i]) begin
        errs++;
        $display("FAIL snapshot step=%0d slot=%0d got seg=%h want seg=%h",
                 i, sl[i], seg_port, exp_s[i]);
      end
    end
  endtask

  task automatic test_blink_reset();
    int         sl[5]    = '{1, 0, 3, 2, 1};
    logic [7:0] exp_s[5] = '{8'hFF, 8'h99, 8'hF9, 8'hA4, 8'hB0};
    digit_value = 16'h1234; blink_en = 4'b0010; zero_fill = 1'b0; brightness = 4'hF;
    do_reset();
    goto(1, 5);
    vec++;
    if (seg_port !== 8'hB0) begin
      errs++;
      $display("FAIL blink_before got seg=%h want seg=b0", seg_port);
    end
    blink_tick = 1'b1; step(); blink_tick = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 4) begin
        blink_tick = 1'b1; step(); blink_tick = 1'b0;
      end
      goto(sl[i], 5);
      vec++;
      if (seg_port !== exp_s[i]) begin
        errs++;
        $display("FAIL blink step=%0d slot=%0d got seg=%h want seg=%h",
                 i, sl[i], seg_port, exp_s[i]);
      end
    end
    blink_tick = 1'b1; step(); blink_tick = 1'b0;
    goto(1, 8);
    vec++;
    if (seg_port !== 8'hFF) begin
      errs++;
      $display("FAIL blink_again got seg=%h want seg=ff", seg_port);
    end
    rst_n = 1'b0;
    blink_tick = 1'b1;
    step();
    blink_tick = 1'b0;
    vec++;
    if (seg_port !== 8'hFF || dig_port !== 4'hF || frame_done !== 1'b0) begin
      errs++;
      $display("FAIL midslot_reset got seg=%h dig=%h fd=%b want seg=ff dig=f fd=0",
               seg_port, dig_port, frame_done);
    end
    step();
    rst_n = 1'b1;
    k = 0;
    step();
    step();
    vec++;
    if (dig_port !== 4'h7 || seg_port !== 8'hF9) begin
      errs++;
      $display("FAIL restart_digit3 got seg=%h dig=%h want seg=f9 dig=7", seg_port, dig_port);
    end
    goto(1, 5);
    vec++;
    if (seg_port !== 8'hB0) begin
      errs++;
      $display("FAIL phase_cleared got seg=%h want seg=b0", seg_port);
    end
    blink_en = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_suppress();
    test_dp_suppress();
    test_brightness();
    test_snapshot();
    test_blink_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule

// File: doc/seven_segment_scan_driver.md
Name: seven_segment_scan_driver

Overview:
Parametrised multiplexed seven-segment display driver for N hex digits. It adds the following to the existing 4-digit scanner:
- per-digit decimal points
- frame-coherent input snapshot
- leading-zero suppression that respects decimal points
- PWM brightness control
- per-digit blink
- an anti-ghosting guard cycle

It sits between the display-value logic, such as generation/score counters, and the board LED pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (>=1)
REFRESH_CYCLES, 6000, clk_in cycles per digit slot (>=2)
BRIGHT_BITS, 4, width of brightness input
SEG_ACTIVE_LOW, 1, 1: segment pins lit when 0; 0: lit when 1
DIG_ACTIVE_LOW, 1, 1: digit-select pins active 0; 0: active 1

Ports:
clk_in  in  1  clock
rst_n  in  1  synchronous, active-low reset
digit_value  in  4*NUM_DIGITS  hex nibbles; nibble i = digit i; digit 0 is least significant/rightmost
dp  in  NUM_DIGITS  decimal point request per digit
zero_fill  in  1  1: show leading zeros; 0: suppress them
brightness  in  BRIGHT_BITS  0 = dark, all-ones = full on
blink_en  in  NUM_DIGITS  per-digit blink enable
blink_tick  in  1  single-cycle pulse that toggles the blink phase
seg_port  out  8  [6:0] = segments g..a, [7] = dp, polarity per SEG_ACTIVE_LOW
dig_port  out  NUM_DIGITS  one-hot digit select, polarity per DIG_ACTIVE_LOW
frame_done  out  1  one-cycle pulse at the end of each full scan

Behaviour:
- Reset (rst_n=0 at a clk_in edge):
  - seg_port and dig_port go to their inactive levels (all 1s when active-low).
  - frame_done=0, blink_phase=0.
  - Slot index cur=NUM_DIGITS-1; slot counter cnt=0.
  - The snapshot registers load digit_value, dp, zero_fill, brightness and blink_en every reset cycle.
- Counters:
  - cnt counts 0..REFRESH_CYCLES-1, width $clog2(REFRESH_CYCLES).
  - On wrap, cur decrements. Scan order is MSB digit first, i.e. NUM_DIGITS-1 down to 0.
  - When cur=0 wraps, cur returns to NUM_DIGITS-1 and the snapshot reloads. All display decisions in a frame use snapshot values only.
- Outputs are registered: values in cycle k+1 reflect counter state in cycle k.
- Guard cycle: at cnt==0, seg_port and dig_port are both inactive.
- On window:
  - on_limit = REFRESH_CYCLES-1 if brightness is all-ones; otherwise (brightness*(REFRESH_CYCLES-1))>>BRIGHT_BITS.
  - For cnt in [1,on_limit], dig_port selects digit cur. At all other cnt, dig_port is inactive.
  - The multiply uses full width with no truncation before the shift.
- Segment encoding (logical 1 = lit, before polarity) for 0..F:
  3F 06 5B 4F 66 6D 7D 07 7F 6F 77 7C 39 5E 79 71
  - Bit 7 = dp[cur].
  - seg_port is inverted when SEG_ACTIVE_LOW=1.
- Leading-zero suppression, digit i:
  - Digit i is suppressed when zero_fill=0, i!=0, and for every j>=i: nibble j==0 and dp[j]==0.
  - A suppressed digit drives all segments unlit, including dp. Digit select still follows the on window.
  - Digit 0 is never suppressed.
- Blink:
  - blink_phase toggles on each cycle where blink_tick=1, independent of frame timing.
  - While blink_phase=1, digits with blink_en=1 (snapshot) drive all segments unlit.
  - blink_tick during reset is ignored.
- frame_done: asserted for the single output cycle corresponding to cnt==REFRESH_CYCLES-1 with cur==0.
- Reset mid-slot: outputs are inactive on the next cycle, and scanning restarts at digit NUM_DIGITS-1 with cnt=0.
- brightness=0: dig_port is permanently inactive; frame_done timing is unchanged.
- Simultaneous frame wrap and input change: the new value is captured into the snapshot and used for the whole next frame.

Test Plan:
Common setup for all scenarios except 4: NUM_DIGITS=4, REFRESH_CYCLES=16, BRIGHT_BITS=4, both polarities active-low, brightness=15.

1. Reset: hold rst_n=0 for 3 cycles -> seg_port=FF, dig_port=F, frame_done=0. Release -> first selected digit is digit 3 (dig_port=7) at cycle 2; frame_done pulses every 64 cycles.
2. Value 0x00A0, dp=0, zero_fill=0 -> slots 3 and 2: seg_port=FF; slot 1: seg_port=88 with dig_port=D; slot 0: seg_port=C0 with dig_port=E.
   Same value with zero_fill=1 -> slots 3 and 2 show C0.
3. Value 0x0000, dp=0100, zero_fill=0 -> slot 3: FF; slot 2: 40; slot 1: C0; slot 0: C0.
4. Brightness, REFRESH_CYCLES=16:
   - brightness=8 -> exactly 7 active dig_port cycles per slot, cnt 1..7.
   - brightness=15 -> 15 active cycles; cnt==0 is always inactive.
   - brightness=0 -> dig_port stays F; frame_done period stays 64.
5. Snapshot: change digit_value from 0x1234 to 0x5678 during slot 2 -> the rest of the frame still shows 2,3,4; the next frame shows 5,6,7,8 starting at slot 3.
6. Blink and reset:
   - blink_en=0010, one blink_tick pulse -> digit 1 shows FF while other digits are unchanged; a second pulse restores digit 1.
   - rst_n=0 mid-slot 1 -> next cycle shows FF/F; the scan restarts at digit 3 and blink_phase=0.
